ctrl_multicycle_fsm: RTL and testbench
======================================

Name: ctrl_multicycle_fsm

Overview:
Multicycle control unit that drives the datapath select lines and write enables, including the 2-bit ALU source-B select, ALU source-A, ALU operation, PC source and register-file muxes. It is the producer side of every mux select and enable in the multicycle MIPS datapath. It sequences fetch, decode, execute, memory and writeback for a subset: add, sub, and, addi, lw, sw, beq, bne, j. Opcode/funct constants and select encodings come from a shared package.

Parameters:
MEM_LAT, 1, extra wait cycles before memory read data is valid (0..7)
SP_INIT, 227, value loaded into $29 after reset; forwarded to datapath constant mux, not used internally

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
opcode  in  6  IR[31:26]
funct  in  6  IR[5:0]
zero  in  1  ALU zero flag
alusrca  out  1  0=PC, 1=A
alusrcb  out  2  00=B, 01=constant 4, 10=sign-ext imm, 11=sign-ext imm<<2
aluop  out  3  001=add, 010=sub, 011=and
iord  out  1  memory address: 0=PC, 1=ALUOut
mem_wr  out  1  memory write strobe
ir_write  out  1  load IR
mdr_write  out  1  load MDR
ab_write  out  1  load A and B
aluout_write  out  1  load ALUOut
reg_write  out  1  register-file write
reg_dst  out  2  00=rt, 01=rd, 10=$29
mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=SP_INIT constant
pc_source  out  2  00=ALU result, 01=ALUOut, 10=jump target
pc_write  out  1  PC load (already qualified with zero for branches)
state_dbg  out  4  current state code, for bench and waveform

Behaviour:
- Moore outputs decoded from state, plus counter. Exception: pc_write in BEQ/BNE is combinational on zero.
- Every output not listed for a state is 0.
- Reset:
  - reset high at a clk edge: state<=RST_SP and wait counter<=0.
  - Held reset keeps state at RST_SP.
  - Reset mid-operation (any state) aborts the instruction. No mem_wr or reg_write leaks into the cycle after the edge, other than the RST_SP write.
- RST_SP: reg_write=1, reg_dst=10, mem_to_reg=10. With reset low, lasts 1 cycle, then FETCH.
- FETCH:
  - Lasts MEM_LAT+1 cycles, counted by a 3-bit counter.
  - All cycles: iord=0, alusrca=0, alusrcb=01, aluop=001, pc_source=00.
  - Final cycle only: ir_write=1, pc_write=1. Counter clears, then DECODE.
- DECODE (1 cycle): alusrca=0, alusrcb=11, aluop=001, aluout_write=1, ab_write=1. Next state:
  - opcode 0x00: funct 0x20/0x22/0x24 -> R_EXEC; any other funct -> FETCH.
  - 0x08 -> ADDI_EXEC; 0x23 or 0x2B -> ADDR; 0x04 -> BEQ; 0x05 -> BNE; 0x02 -> JUMP.
  - Any other opcode -> FETCH (treated as nop, no trap).
- R_EXEC: alusrca=1, alusrcb=00, aluop from funct (0x20->001, 0x22->010, 0x24->011), aluout_write=1 -> R_WB.
- R_WB: reg_write=1, reg_dst=01, mem_to_reg=00 -> FETCH.
- ADDI_EXEC: alusrca=1, alusrcb=10, aluop=001, aluout_write=1 -> ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=00, mem_to_reg=00 -> FETCH.
- ADDR: alusrca=1, alusrcb=10, aluop=001, aluout_write=1 -> LW_MEM if opcode 0x23, else SW_MEM.
- LW_MEM: iord=1 for MEM_LAT+1 cycles; mdr_write=1 on the final cycle -> LW_WB.
- LW_WB: reg_write=1, reg_dst=00, mem_to_reg=01 -> FETCH.
- SW_MEM: iord=1, mem_wr=1 for exactly 1 cycle -> FETCH.
- BEQ: alusrca=1, alusrcb=00, aluop=010, pc_source=01, pc_write=zero -> FETCH.
- BNE: as BEQ, but pc_write=!zero -> FETCH.
- JUMP: pc_source=10, pc_write=1 -> FETCH.
- Opcode and funct are sampled only in DECODE and R_EXEC/ADDR; IR is stable there.
- Illegal state encodings -> FETCH on the next edge.

Decomposition:
- Package ctrl_pkg holds:
  - state enum (4-bit)
  - opcode/funct localparams
  - ALUSRCB_*, ALUOP_*, REGDST_*, MEMTOREG_*, PCSRC_* encodings
- No sub-module: state register, wait counter and output decode live in one always_ff plus one always_comb.

Test Plan:
- Reset high 3 cycles, then low:
  - state_dbg=RST_SP with reg_write=1, reg_dst=10, mem_to_reg=10 for exactly 1 cycle.
  - Then FETCH with alusrcb=01, aluop=001.
- MEM_LAT=1, opcode 0x00, funct 0x22 (sub):
  - FETCH 2 cycles (ir_write/pc_write only in the 2nd), DECODE alusrcb=11.
  - R_EXEC aluop=010, alusrcb=00, R_WB reg_dst=01.
  - Back in FETCH after 5 cycles total.
- lw, opcode 0x23, MEM_LAT=1:
  - ADDR alusrcb=10, then LW_MEM iord=1 for 2 cycles with mdr_write only in the 2nd.
  - LW_WB mem_to_reg=01; mem_wr never 1.
- sw, opcode 0x2B: mem_wr=1 in exactly one cycle, with iord=1; reg_write stays 0 throughout.
- Branches:
  - beq with zero=1 -> pc_write=1, pc_source=01; beq with zero=0 -> pc_write=0.
  - bne with zero=0 -> pc_write=1.
  - Toggle zero within the cycle: pc_write follows combinationally.
- Robustness:
  - opcode 0x3F -> DECODE then FETCH, no reg_write/mem_wr.
  - reset asserted during the 1st LW_MEM cycle -> next edge state_dbg=RST_SP, counter=0, mdr_write=0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared constants for the multicycle MIPS control unit: state codes,
// instruction opcode/funct values and datapath select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RST_SP    = 4'd0,
        S_FETCH     = 4'd1,
        S_DECODE    = 4'd2,
        S_R_EXEC    = 4'd3,
        S_R_WB      = 4'd4,
        S_ADDI_EXEC = 4'd5,
        S_ADDI_WB   = 4'd6,
        S_ADDR      = 4'd7,
        S_LW_MEM    = 4'd8,
        S_LW_WB     = 4'd9,
        S_SW_MEM    = 4'd10,
        S_BEQ       = 4'd11,
        S_BNE       = 4'd12,
        S_JUMP      = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;

    localparam logic [1:0] ALUSRCB_B      = 2'b00;
    localparam logic [1:0] ALUSRCB_FOUR   = 2'b01;
    localparam logic [1:0] ALUSRCB_IMM    = 2'b10;
    localparam logic [1:0] ALUSRCB_IMMSH2 = 2'b11;

    localparam logic [2:0] ALUOP_NONE = 3'b000;
    localparam logic [2:0] ALUOP_ADD  = 3'b001;
    localparam logic [2:0] ALUOP_SUB  = 3'b010;
    localparam logic [2:0] ALUOP_AND  = 3'b011;

    localparam logic [1:0] REGDST_RT = 2'b00;
    localparam logic [1:0] REGDST_RD = 2'b01;
    localparam logic [1:0] REGDST_SP = 2'b10;

    localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
    localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
    localparam logic [1:0] MEMTOREG_SPINIT = 2'b10;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Maps a supported R-type funct to its ALU operation; unknown codes give no operation.
    function automatic logic [2:0] funct_to_aluop(input logic [5:0] fn);
        case (fn)
            FN_ADD:  funct_to_aluop = ALUOP_ADD;
            FN_SUB:  funct_to_aluop = ALUOP_SUB;
            FN_AND:  funct_to_aluop = ALUOP_AND;
            default: funct_to_aluop = ALUOP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ctrl_multicycle_fsm.sv
// Multicycle MIPS control unit: sequences fetch/decode/execute/memory/writeback
// and drives every datapath select and write enable. Outputs are Moore-decoded
// from the state (and wait counter), except branch pc_write which follows zero.
module ctrl_multicycle_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int SP_INIT = 227
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [2:0] aluop,
    output logic       iord,
    output logic       mem_wr,
    output logic       ir_write,
    output logic       mdr_write,
    output logic       ab_write,
    output logic       aluout_write,
    output logic       reg_write,
    output logic [1:0] reg_dst,
    output logic [1:0] mem_to_reg,
    output logic [1:0] pc_source,
    output logic       pc_write,
    output logic [3:0] state_dbg
);

    // SP_INIT only feeds the datapath constant mux; here it is merely range-checked.
    if (MEM_LAT < 0 || MEM_LAT > 7) begin : g_bad_mem_lat
        $error("ctrl_multicycle_fsm: MEM_LAT must be within 0..7");
    end
    if (SP_INIT < 0) begin : g_bad_sp_init
        $error("ctrl_multicycle_fsm: SP_INIT must be non-negative");
    end

    localparam logic [2:0] LAST_WAIT = 3'(MEM_LAT);

    state_t     state;
    state_t     state_next;
    logic [2:0] wait_cnt;
    logic [2:0] wait_cnt_next;
    logic       wait_done;

    assign wait_done = (wait_cnt == LAST_WAIT);
    assign state_dbg = state;

    // State register and memory wait counter; reset parks in RST_SP with a cleared counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_RST_SP;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Next-state selection and output decode; every output defaults to 0.
    always_comb begin
        state_next    = S_FETCH;
        wait_cnt_next = 3'd0;
        alusrca       = 1'b0;
        alusrcb       = ALUSRCB_B;
        aluop         = ALUOP_NONE;
        iord          = 1'b0;
        mem_wr        = 1'b0;
        ir_write      = 1'b0;
        mdr_write     = 1'b0;
        ab_write      = 1'b0;
        aluout_write  = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = REGDST_RT;
        mem_to_reg    = MEMTOREG_ALUOUT;
        pc_source     = PCSRC_ALU;
        pc_write      = 1'b0;

        case (state)
            S_RST_SP: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_SP;
                mem_to_reg = MEMTOREG_SPINIT;
                state_next = S_FETCH;
            end
            S_FETCH: begin
                iord      = 1'b0;
                alusrca   = 1'b0;
                alusrcb   = ALUSRCB_FOUR;
                aluop     = ALUOP_ADD;
                pc_source = PCSRC_ALU;
                if (wait_done) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else begin
                    wait_cnt_next = wait_cnt + 3'd1;
                    state_next    = S_FETCH;
                end
            end
            S_DECODE: begin
                alusrca      = 1'b0;
                alusrcb      = ALUSRCB_IMMSH2;
                aluop        = ALUOP_ADD;
                aluout_write = 1'b1;
                ab_write     = 1'b1;
                case (opcode)
                    OP_RTYPE: state_next = (funct_to_aluop(funct) != ALUOP_NONE) ? S_R_EXEC : S_FETCH;
                    OP_ADDI:  state_next = S_ADDI_EXEC;
                    OP_LW,
                    OP_SW:    state_next = S_ADDR;
                    OP_BEQ:   state_next = S_BEQ;
                    OP_BNE:   state_next = S_BNE;
                    OP_J:     state_next = S_JUMP;
                    default:  state_next = S_FETCH;
                endcase
            end
            S_R_EXEC: begin
                alusrca      = 1'b1;
                alusrcb      = ALUSRCB_B;
                aluop        = funct_to_aluop(funct);
                aluout_write = 1'b1;
                state_next   = S_R_WB;
            end
            S_R_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RD;
                mem_to_reg = MEMTOREG_ALUOUT;
                state_next = S_FETCH;
            end
            S_ADDI_EXEC: begin
                alusrca      = 1'b1;
                alusrcb      = ALUSRCB_IMM;
                aluop        = ALUOP_ADD;
                aluout_write = 1'b1;
                state_next   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = MEMTOREG_ALUOUT;
                state_next = S_FETCH;
            end
            S_ADDR: begin
                alusrca      = 1'b1;
                alusrcb      = ALUSRCB_IMM;
                aluop        = ALUOP_ADD;
                aluout_write = 1'b1;
                state_next   = (opcode == OP_LW) ? S_LW_MEM : S_SW_MEM;
            end
            S_LW_MEM: begin
                iord = 1'b1;
                if (wait_done) begin
                    mdr_write  = 1'b1;
                    state_next = S_LW_WB;
                end else begin
                    wait_cnt_next = wait_cnt + 3'd1;
                    state_next    = S_LW_MEM;
                end
            end
            S_LW_WB: begin
                reg_write  = 1'b1;
                reg_dst    = REGDST_RT;
                mem_to_reg = MEMTOREG_MDR;
                state_next = S_FETCH;
            end
            S_SW_MEM: begin
                iord       = 1'b1;
                mem_wr     = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                alusrca    = 1'b1;
                alusrcb    = ALUSRCB_B;
                aluop      = ALUOP_SUB;
                pc_source  = PCSRC_ALUOUT;
                pc_write   = zero;
                state_next = S_FETCH;
            end
            S_BNE: begin
                alusrca    = 1'b1;
                alusrcb    = ALUSRCB_B;
                aluop      = ALUOP_SUB;
                pc_source  = PCSRC_ALUOUT;
                pc_write   = ~zero;
                state_next = S_FETCH;
            end
            S_JUMP: begin
                pc_source  = PCSRC_JUMP;
                pc_write   = 1'b1;
                state_next = S_FETCH;
            end
            default: begin
                state_next = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_ctrl_multicycle_fsm.sv
// Directed bench for ctrl_multicycle_fsm with MEM_LAT=1: walks each instruction
// class cycle by cycle and compares selects/enables against hand-derived values.
module tb_ctrl_multicycle_fsm;
    import ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [2:0] aluop;
    logic       iord;
    logic       mem_wr;
    logic       ir_write;
    logic       mdr_write;
    logic       ab_write;
    logic       aluout_write;
    logic       reg_write;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic [1:0] pc_source;
    logic       pc_write;
    logic [3:0] state_dbg;

    int checkCount = 0;
    int passCount  = 0;

    ctrl_multicycle_fsm #(.MEM_LAT(1), .SP_INIT(227)) dut (
        .clk          (clk),
        .reset        (reset),
        .opcode       (opcode),
        .funct        (funct),
        .zero         (zero),
        .alusrca      (alusrca),
        .alusrcb      (alusrcb),
        .aluop        (aluop),
        .iord         (iord),
        .mem_wr       (mem_wr),
        .ir_write     (ir_write),
        .mdr_write    (mdr_write),
        .ab_write     (ab_write),
        .aluout_write (aluout_write),
        .reg_write    (reg_write),
        .reg_dst      (reg_dst),
        .mem_to_reg   (mem_to_reg),
        .pc_source    (pc_source),
        .pc_write     (pc_write),
        .state_dbg    (state_dbg)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One compare point: counts the check and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    endtask

    // Drives the instruction fields and zero flag.
    task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn, input logic z);
        opcode = op;
        funct  = fn;
        zero   = z;
    endtask

    // Advances one clock and settles just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks the two FETCH cycles (MEM_LAT=1), loads the next instruction, enters DECODE.
    task automatic fetchInto(input string tag, input logic [5:0] op, input logic [5:0] fn);
        checkOutput({tag, "_f0_state"}, state_dbg, S_FETCH);
        checkOutput({tag, "_f0_irw"}, {7'd0, ir_write}, 8'd0);
        checkOutput({tag, "_f0_pcw"}, {7'd0, pc_write}, 8'd0);
        step();
        checkOutput({tag, "_f1_state"}, state_dbg, S_FETCH);
        checkOutput({tag, "_f1_irw"}, {7'd0, ir_write}, 8'd1);
        checkOutput({tag, "_f1_pcw"}, {7'd0, pc_write}, 8'd1);
        applyStimulus(op, fn, 1'b0);
        step();
        checkOutput({tag, "_dec_state"}, state_dbg, S_DECODE);
        checkOutput({tag, "_dec_srcb"}, {6'd0, alusrcb}, 8'h3);
    endtask

    initial begin
        $display("[TB] starting ctrl_multicycle_fsm bench");
        reset = 1'b1;
        applyStimulus(6'h00, 6'h00, 1'b0);

        // Reset held three edges
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("rst_state", state_dbg, S_RST_SP);
        end
        reset = 1'b0;
        checkOutput("rstsp_regw", {7'd0, reg_write}, 8'd1);
        checkOutput("rstsp_regdst", {6'd0, reg_dst}, 8'h2);
        checkOutput("rstsp_m2r", {6'd0, mem_to_reg}, 8'h2);
        step();
        checkOutput("fetch_regw", {7'd0, reg_write}, 8'd0);
        checkOutput("fetch_srcb", {6'd0, alusrcb}, 8'h1);
        checkOutput("fetch_aluop", {5'd0, aluop}, 8'h1);
        checkOutput("fetch_iord", {7'd0, iord}, 8'd0);

        // sub: R_EXEC then R_WB
        fetchInto("sub", 6'h00, 6'h22);
        step();
        checkOutput("sub_exec_state", state_dbg, S_R_EXEC);
        checkOutput("sub_exec_aluop", {5'd0, aluop}, 8'h2);
        checkOutput("sub_exec_srcb", {6'd0, alusrcb}, 8'h0);
        checkOutput("sub_exec_srca", {7'd0, alusrca}, 8'd1);
        step();
        checkOutput("sub_wb_state", state_dbg, S_R_WB);
        checkOutput("sub_wb_regdst", {6'd0, reg_dst}, 8'h1);
        checkOutput("sub_wb_regw", {7'd0, reg_write}, 8'd1);
        step();

        // lw: ADDR, two LW_MEM cycles, LW_WB
        fetchInto("lw", 6'h23, 6'h00);
        step();
        checkOutput("lw_addr_state", state_dbg, S_ADDR);
        checkOutput("lw_addr_srcb", {6'd0, alusrcb}, 8'h2);
        step();
        checkOutput("lw_m0_state", state_dbg, S_LW_MEM);
        checkOutput("lw_m0_iord", {7'd0, iord}, 8'd1);
        checkOutput("lw_m0_mdrw", {7'd0, mdr_write}, 8'd0);
        checkOutput("lw_m0_memwr", {7'd0, mem_wr}, 8'd0);
        step();
        checkOutput("lw_m1_state", state_dbg, S_LW_MEM);
        checkOutput("lw_m1_iord", {7'd0, iord}, 8'd1);
        checkOutput("lw_m1_mdrw", {7'd0, mdr_write}, 8'd1);
        checkOutput("lw_m1_memwr", {7'd0, mem_wr}, 8'd0);
        step();
        checkOutput("lw_wb_state", state_dbg, S_LW_WB);
        checkOutput("lw_wb_m2r", {6'd0, mem_to_reg}, 8'h1);
        checkOutput("lw_wb_regw", {7'd0, reg_write}, 8'd1);
        checkOutput("lw_wb_memwr", {7'd0, mem_wr}, 8'd0);
        step();

        // sw: single write strobe, no register write
        fetchInto("sw", 6'h2B, 6'h00);
        checkOutput("sw_dec_regw", {7'd0, reg_write}, 8'd0);
        step();
        checkOutput("sw_addr_memwr", {7'd0, mem_wr}, 8'd0);
        step();
        checkOutput("sw_mem_state", state_dbg, S_SW_MEM);
        checkOutput("sw_mem_memwr", {7'd0, mem_wr}, 8'd1);
        checkOutput("sw_mem_iord", {7'd0, iord}, 8'd1);
        checkOutput("sw_mem_regw", {7'd0, reg_write}, 8'd0);
        step();
        checkOutput("sw_after_memwr", {7'd0, mem_wr}, 8'd0);

        // beq: pc_write tracks zero within the cycle
        fetchInto("beq", 6'h04, 6'h00);
        zero = 1'b1;
        step();
        checkOutput("beq_state", state_dbg, S_BEQ);
        checkOutput("beq_z1_pcw", {7'd0, pc_write}, 8'd1);
        checkOutput("beq_pcsrc", {6'd0, pc_source}, 8'h1);
        checkOutput("beq_aluop", {5'd0, aluop}, 8'h2);
        zero = 1'b0;
        #1;
        checkOutput("beq_z0_pcw", {7'd0, pc_write}, 8'd0);
        step();

        // bne: inverted branch condition
        fetchInto("bne", 6'h05, 6'h00);
        step();
        checkOutput("bne_state", state_dbg, S_BNE);
        checkOutput("bne_z0_pcw", {7'd0, pc_write}, 8'd1);
        zero = 1'b1;
        #1;
        checkOutput("bne_z1_pcw", {7'd0, pc_write}, 8'd0);
        zero = 1'b0;
        step();

        // j: unconditional PC load from jump target
        fetchInto("j", 6'h02, 6'h00);
        step();
        checkOutput("j_state", state_dbg, S_JUMP);
        checkOutput("j_pcsrc", {6'd0, pc_source}, 8'h2);
        checkOutput("j_pcw", {7'd0, pc_write}, 8'd1);
        step();

        // addi: immediate source, write to rt
        fetchInto("addi", 6'h08, 6'h00);
        step();
        checkOutput("addi_exec_state", state_dbg, S_ADDI_EXEC);
        checkOutput("addi_exec_srcb", {6'd0, alusrcb}, 8'h2);
        step();
        checkOutput("addi_wb_state", state_dbg, S_ADDI_WB);
        checkOutput("addi_wb_regdst", {6'd0, reg_dst}, 8'h0);
        checkOutput("addi_wb_regw", {7'd0, reg_write}, 8'd1);
        step();

        // Unknown opcode and unknown funct fall back to FETCH
        fetchInto("op3f", 6'h3F, 6'h00);
        checkOutput("op3f_regw", {7'd0, reg_write}, 8'd0);
        checkOutput("op3f_memwr", {7'd0, mem_wr}, 8'd0);
        step();
        fetchInto("badfn", 6'h00, 6'h01);
        step();
        checkOutput("badfn_next_state", state_dbg, S_FETCH);
        checkOutput("badfn_regw", {7'd0, reg_write}, 8'd0);

        // Reset during the first LW_MEM cycle aborts the load
        fetchInto("lwrst", 6'h23, 6'h00);
        step();
        step();
        checkOutput("lwrst_m0_state", state_dbg, S_LW_MEM);
        reset = 1'b1;
        step();
        checkOutput("lwrst_state", state_dbg, S_RST_SP);
        checkOutput("lwrst_mdrw", {7'd0, mdr_write}, 8'd0);
        checkOutput("lwrst_memwr", {7'd0, mem_wr}, 8'd0);
        reset = 1'b0;
        step();
        checkOutput("lwrst_f0_state", state_dbg, S_FETCH);
        checkOutput("lwrst_f0_irw", {7'd0, ir_write}, 8'd0);
        step();
        checkOutput("lwrst_f1_irw", {7'd0, ir_write}, 8'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
